ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
Multi-cycle divide sequencer in the EX stage, directly upstream of the combinational signed divider array.
- Accepts one divide request, registers the operands and resolves special cases (divide-by-zero, signed overflow).
- Routes the request to the signed array (multicycle path) or to an internal radix-2 unsigned iterator.
- Selects quotient or remainder, returns a 32-bit result and stalls the pipeline while busy.

Parameters:
DATA_W, 32, operand/result width (matches DATA_BUS_WIDTH)
SETTLE_CYCLES, 2, cycles the array inputs are held before its result is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
div_req  in  1  request valid from EX decode
div_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
div_op1  in  DATA_W  dividend
div_op2  in  DATA_W  divisor
flush  in  1  pipeline flush; aborts any operation
div_ready  out  1  high in IDLE; request accepted when div_req & div_ready
div_busy  out  1  stall to pipeline; high from acceptance through DONE
div_result_valid  out  1  one-cycle pulse, result available
div_result  out  DATA_W  quotient or remainder
arr_en  out  1  enable to signed array (div_en)
arr_op1  out  DATA_W  registered dividend to array
arr_op2  out  DATA_W  registered divisor to array
arr_result  in  2*DATA_W  array output {rem, quo}

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all registers 0. Outputs: div_ready=1, div_busy=0, div_result_valid=0, div_result=0, arr_en=0, arr_op1=0, arr_op2=0.
- States: IDLE, ARRAY, ITER, DONE.
- Acceptance edge (IDLE, div_req=1, flush=0): latch op and operands, set div_busy=1, then classify:
  - divisor==0 -> DONE. Quotient = all ones; remainder = dividend (all ops).
  - signed op, dividend==0x8000_0000, divisor==all ones -> DONE. Quotient = 0x8000_0000; remainder = 0.
  - signed op otherwise, or unsigned op with both operand MSBs 0 -> ARRAY. Counter = SETTLE_CYCLES-1.
  - unsigned op otherwise -> ITER. Counter = DATA_W-1; partial remainder = 0.
- ARRAY:
  - arr_en=1; arr_op1/arr_op2 hold the latched operands.
  - Counter decrements each cycle. At 0, capture arr_result[DATA_W-1:0] as quotient and arr_result[2*DATA_W-1:DATA_W] as remainder, then go to DONE.
  - arr_en=0 in every other state.
- ITER:
  - Restoring, one quotient bit per cycle, MSB first.
  - Each cycle: shift dividend bit into the partial remainder (DATA_W+1 bits); if it is >= divisor, subtract and set the quotient bit.
  - After DATA_W cycles (counter 0), go to DONE.
- DONE:
  - div_result_valid=1 for exactly one cycle.
  - div_result = quotient for DIV/DIVU, remainder for REM/REMU. div_result holds its value after DONE until the next DONE.
  - Next state IDLE; div_busy drops.
- Latency, with acceptance at edge N, DONE is the state during cycle:
  - special case: N+1
  - array path: N+1+SETTLE_CYCLES
  - iterative path: N+1+DATA_W
- div_req while busy is ignored; the requester must hold it until div_ready.
- flush=1 in any state:
  - next state IDLE, counter cleared, arr_en=0.
  - No div_result_valid is produced for the aborted operation; div_result is not updated.
  - flush wins over a simultaneous div_req in IDLE, so no acceptance occurs.
- Sign rules follow the array: quotient truncates toward zero; remainder takes the dividend's sign.

Decomposition:
- Shared package:
  - DIV_OP_DIV/DIVU/REM/REMU encodings
  - state encoding IDLE/ARRAY/ITER/DONE
  - DIV_ZERO_QUO (all ones)
  - SIGNED_MIN constant
- One sub-module, div_iter_unsigned, holds the radix-2 restoring datapath:
  - inputs: start, dividend, divisor, step enable
  - outputs: quotient, remainder
  - the FSM and counter stay in ex_div_ctrl.

Test Plan:
- DIV 100/7 -> arr_en high for 2 cycles; div_result_valid pulse at N+3; div_result=14. Repeat as REM -> 2.
- DIV -100/7 -> 0xFFFF_FFF2 (-14); REM -100/7 -> 0xFFFF_FFFE (-2); REM 100/-7 -> 2.
- DIV 0x1234/0 -> 0xFFFF_FFFF at N+1; REMU 0x1234/0 -> 0x1234; arr_en never asserted.
- DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 at N+1; REM of the same operands -> 0.
- DIVU 0xFFFF_FFFF/3 -> 0x5555_5555, valid at N+33, div_busy high N..N+33. REMU 0x8000_0001/0x8000_0000 -> 1.
- Flush and reset mid-operation:
  - Start DIVU 0xFFFF_FFFF/3, assert flush at N+10 -> no valid pulse, div_ready=1 at N+11; new DIV 9/3 accepted then -> 3.
  - rst_n low mid-ARRAY -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared encodings for the EX-stage divide sequencer.
//   DIV_OP_*      : div_op encodings (bit 0 = unsigned, bit 1 = remainder)
//   S_*           : sequencer state encoding
//   DIV_ZERO_QUO  : quotient returned for a zero divisor
//   SIGNED_MIN    : most negative dividend (signed overflow detection)
// The constants are sized for the default 32-bit datapath.
package ex_div_ctrl_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARRAY = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN   = 32'h8000_0000;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_div_ctrl_div_iter_unsigned.sv
// div_iter_unsigned: radix-2 restoring unsigned divider datapath.
//   clk, rst_n   : clock, async active-low reset
//   start        : load dividend, clear partial remainder
//   step         : produce one quotient bit, MSB first
//   dividend     : dividend loaded on start
//   divisor      : divisor, held stable by the caller while stepping
//   quotient     : quotient after DATA_W steps
//   remainder    : remainder after DATA_W steps
module div_iter_unsigned #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  // quo_q starts as the dividend; each step shifts a dividend bit out of the
  // top and a quotient bit in at the bottom.
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W:0]   rem_shift;

  always_comb begin
    rem_shift = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    quo_d     = quo_q;
    rem_d     = rem_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
    end else if (step) begin
      if (rem_shift >= {1'b0, divisor}) begin
        rem_d = rem_shift - {1'b0, divisor};
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = rem_shift;
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[DATA_W-1:0];

endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle divide sequencer in front of the signed divider array.
//   clk, rst_n        : clock, async active-low reset
//   div_req/div_ready : request handshake (accept when both high)
//   div_op            : 0=DIV 1=DIVU 2=REM 3=REMU
//   div_op1/div_op2   : dividend / divisor
//   flush             : abort, back to IDLE with no result
//   div_busy          : pipeline stall, acceptance through DONE
//   div_result_valid  : one-cycle pulse in DONE
//   div_result        : quotient or remainder, held until the next DONE
//   arr_en/arr_op1/2  : signed array enable and registered operands
//   arr_result        : array output {rem, quo}
//
// state | meaning
// IDLE  | ready for a request
// ARRAY | array inputs settling, sampled when counter reaches 0
// ITER  | unsigned restoring iteration, one bit per cycle
// DONE  | result valid for one cycle
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_req,
  input  logic [1:0]          div_op,
  input  logic [DATA_W-1:0]   div_op1,
  input  logic [DATA_W-1:0]   div_op2,
  input  logic                flush,
  output logic                div_ready,
  output logic                div_busy,
  output logic                div_result_valid,
  output logic [DATA_W-1:0]   div_result,
  output logic                arr_en,
  output logic [DATA_W-1:0]   arr_op1,
  output logic [DATA_W-1:0]   arr_op2,
  input  logic [2*DATA_W-1:0] arr_result
);

  localparam int CNT_MAX = (DATA_W > SETTLE_CYCLES) ? DATA_W : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              iter_q, iter_d;

  logic              it_start, it_step;
  logic [DATA_W-1:0] it_quo, it_rem;
  logic              is_zero, is_ovf, use_array;
  logic [DATA_W-1:0] fin_quo, fin_rem, sel_result;

  // Unsigned operands with both MSBs clear divide identically as signed,
  // so only genuinely large unsigned operands need the slow iterator.
  assign is_zero   = (div_op2 == '0);
  assign is_ovf    = op_is_signed(div_op) && (div_op1 == SIGNED_MIN) &&
                     (div_op2 == DIV_ZERO_QUO);
  assign use_array = op_is_signed(div_op) ||
                     (!div_op1[DATA_W-1] && !div_op2[DATA_W-1]);

  // The iterator's final bit lands on the edge into DONE, so its outputs are
  // read directly instead of being copied into quo_q/rem_q.
  assign fin_quo    = iter_q ? it_quo : quo_q;
  assign fin_rem    = iter_q ? it_rem : rem_q;
  assign sel_result = op_is_rem(op_q) ? fin_rem : fin_quo;

  assign it_step = (state_q == S_ITER);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    hold_d   = hold_q;
    it_start = 1'b0;
    if (state_q == S_DONE) hold_d = sel_result;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_req) begin
            op_d   = div_op;
            op1_d  = div_op1;
            op2_d  = div_op2;
            iter_d = 1'b0;
            if (is_zero) begin
              quo_d   = DIV_ZERO_QUO;
              rem_d   = div_op1;
              state_d = S_DONE;
            end else if (is_ovf) begin
              quo_d   = SIGNED_MIN;
              rem_d   = '0;
              state_d = S_DONE;
            end else if (use_array) begin
              cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
              state_d = S_ARRAY;
            end else begin
              cnt_d    = CNT_W'(DATA_W - 1);
              iter_d   = 1'b1;
              it_start = 1'b1;
              state_d  = S_ITER;
            end
          end
        end
        S_ARRAY: begin
          if (cnt_q == '0) begin
            quo_d   = arr_result[DATA_W-1:0];
            rem_d   = arr_result[2*DATA_W-1:DATA_W];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_ITER: begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      iter_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
      hold_q  <= hold_d;
    end
  end

  div_iter_unsigned #(.DATA_W(DATA_W)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (it_start),
    .step      (it_step),
    .dividend  (div_op1),
    .divisor   (op2_q),
    .quotient  (it_quo),
    .remainder (it_rem)
  );

  assign div_ready        = (state_q == S_IDLE);
  assign div_busy         = (state_q != S_IDLE);
  assign div_result_valid = (state_q == S_DONE);
  assign div_result       = (state_q == S_DONE) ? sel_result : hold_q;
  assign arr_en           = (state_q == S_ARRAY);
  assign arr_op1          = op1_q;
  assign arr_op2          = op2_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
module tb_ex_div_ctrl;
  localparam int W      = 32;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          div_req;
  logic [1:0]    div_op;
  logic [W-1:0]  div_op1, div_op2;
  logic          flush;
  logic          div_ready, div_busy, div_result_valid;
  logic [W-1:0]  div_result;
  logic          arr_en;
  logic [W-1:0]  arr_op1, arr_op2;
  logic [2*W-1:0] arr_result;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int           exp_lat_q[$];

  always #5 clk = ~clk;

  ex_div_ctrl #(.DATA_W(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .div_req(div_req), .div_op(div_op),
    .div_op1(div_op1), .div_op2(div_op2), .flush(flush),
    .div_ready(div_ready), .div_busy(div_busy),
    .div_result_valid(div_result_valid), .div_result(div_result),
    .arr_en(arr_en), .arr_op1(arr_op1), .arr_op2(arr_op2),
    .arr_result(arr_result)
  );

  // Behavioural signed array: truncating quotient, remainder follows dividend.
  always_comb begin
    arr_result = '0;
    if (arr_en && arr_op2 != '0 &&
        !(arr_op1 == 32'h8000_0000 && arr_op2 == 32'hFFFF_FFFF)) begin
      arr_result[W-1:0]   = $signed(arr_op1) / $signed(arr_op2);
      arr_result[2*W-1:W] = $signed(arr_op1) % $signed(arr_op2);
    end
  end

  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, b);
    if (b == '0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!op[0] || (!a[W-1] && !b[W-1])) return 1 + SETTLE;
    return 1 + W;
  endfunction

  // Issues one request from an IDLE cycle (#1 after an edge) and follows it
  // to the DONE cycle; expected values go to the scoreboard on issue.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b,
                        output logic [W-1:0] res, output int lat,
                        output int arr_cycles, output int busy_err, output bit timeout);
    exp_q.push_back(ref_div(op, a, b));
    exp_lat_q.push_back(ref_lat(op, a, b));
    div_req = 1'b1; div_op = op; div_op1 = a; div_op2 = b;
    @(posedge clk); #1;
    div_req = 1'b0;
    lat = 1; arr_cycles = 0; busy_err = 0; timeout = 1'b0; res = '0;
    while (!div_result_valid && lat < 100) begin
      if (arr_en) arr_cycles++;
      if (!div_busy || div_ready) busy_err++;
      @(posedge clk); #1;
      lat++;
    end
    if (!div_result_valid) timeout = 1'b1;
    else begin
      if (arr_en) arr_cycles++;
      if (!div_busy || div_ready) busy_err++;
      res = div_result;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (div_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", div_ready); else n_pass++;
    n_checks++; if (div_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", div_busy); else n_pass++;
    n_checks++; if (div_result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", div_result_valid); else n_pass++;
    n_checks++; if (div_result !== '0) $display("FAIL reset_result got %h want 0", div_result); else n_pass++;
    n_checks++; if (arr_en !== 1'b0) $display("FAIL reset_arr_en got %b want 0", arr_en); else n_pass++;
    n_checks++; if (arr_op1 !== '0 || arr_op2 !== '0)
      $display("FAIL reset_arr_ops got %h/%h want 0/0", arr_op1, arr_op2); else n_pass++;
  endtask

  // Shared body of the per-path tests is written out in each task so every
  // scenario keeps its own comparisons.
  task automatic test_array();
    logic [1:0]   ops[6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd1};
    logic [W-1:0] as[6]  = '{32'd100, 32'd100, -32'sd100, -32'sd100, 32'd100, 32'd50};
    logic [W-1:0] bs[6]  = '{32'd7, 32'd7, 32'd7, 32'd7, -32'sd7, 32'd5};
    logic [W-1:0] res, exp; int lat, arrc, berr, elat; bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, arrc, berr, to);
      exp = exp_q.pop_front(); elat = exp_lat_q.pop_front();
      n_checks++;
      if (to) begin $display("FAIL array_timeout op%0d no valid within bound", i); return; end
      n_pass++;
      n_checks++; if (res !== exp) $display("FAIL array_result op%0d got %h want %h", i, res, exp); else n_pass++;
      n_checks++; if (lat !== elat) $display("FAIL array_latency op%0d got %0d want %0d", i, lat, elat); else n_pass++;
      n_checks++; if (arrc !== SETTLE) $display("FAIL array_arr_en op%0d got %0d cycles want %0d", i, arrc, SETTLE); else n_pass++;
      n_checks++; if (berr !== 0) $display("FAIL array_busy op%0d got %0d bad cycles want 0", i, berr); else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (div_result_valid !== 1'b0 || div_ready !== 1'b1 || div_result !== exp)
        $display("FAIL array_after op%0d got valid=%b ready=%b res=%h want 0/1/%h",
                 i, div_result_valid, div_ready, div_result, exp);
      else n_pass++;
    end
  endtask

  task automatic test_special();
    logic [1:0]   ops[5] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [W-1:0] as[5]  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd5};
    logic [W-1:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] res, exp; int lat, arrc, berr, elat; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, arrc, berr, to);
      exp = exp_q.pop_front(); elat = exp_lat_q.pop_front();
      n_checks++;
      if (to) begin $display("FAIL special_timeout op%0d no valid within bound", i); return; end
      n_pass++;
      n_checks++; if (res !== exp) $display("FAIL special_result op%0d got %h want %h", i, res, exp); else n_pass++;
      n_checks++; if (lat !== elat) $display("FAIL special_latency op%0d got %0d want %0d", i, lat, elat); else n_pass++;
      n_checks++; if (arrc !== 0) $display("FAIL special_arr_en op%0d got %0d cycles want 0", i, arrc); else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (div_result_valid !== 1'b0 || div_busy !== 1'b0 || div_result !== exp)
        $display("FAIL special_after op%0d got valid=%b busy=%b res=%h want 0/0/%h",
                 i, div_result_valid, div_busy, div_result, exp);
      else n_pass++;
    end
  endtask

  task automatic test_iter();
    logic [1:0]   ops[4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [W-1:0] as[4]  = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [W-1:0] bs[4]  = '{32'd3, 32'h8000_0000, 32'd7, 32'h8000_0000};
    logic [W-1:0] res, exp; int lat, arrc, berr, elat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, arrc, berr, to);
      exp = exp_q.pop_front(); elat = exp_lat_q.pop_front();
      n_checks++;
      if (to) begin $display("FAIL iter_timeout op%0d no valid within bound", i); return; end
      n_pass++;
      n_checks++; if (res !== exp) $display("FAIL iter_result op%0d got %h want %h", i, res, exp); else n_pass++;
      n_checks++; if (lat !== elat) $display("FAIL iter_latency op%0d got %0d want %0d", i, lat, elat); else n_pass++;
      n_checks++; if (arrc !== 0) $display("FAIL iter_arr_en op%0d got %0d cycles want 0", i, arrc); else n_pass++;
      n_checks++; if (berr !== 0) $display("FAIL iter_busy op%0d got %0d bad cycles want 0", i, berr); else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (div_result_valid !== 1'b0 || div_result !== exp)
        $display("FAIL iter_after op%0d got valid=%b res=%h want 0/%h", i, div_result_valid, div_result, exp);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] prev, res, exp; int nvalid, lat, arrc, berr, elat; bit to;
    prev = div_result;
    div_req = 1'b1; div_op = 2'd1; div_op1 = 32'hFFFF_FFFF; div_op2 = 32'd3;
    @(posedge clk); #1;
    div_req = 1'b0;
    nvalid = 0;
    for (int c = 1; c < 10; c++) begin
      if (div_result_valid) nvalid++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    if (div_result_valid) nvalid++;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (div_ready !== 1'b1 || div_busy !== 1'b0)
      $display("FAIL flush_idle got ready=%b busy=%b want 1/0", div_ready, div_busy); else n_pass++;
    n_checks++; if (nvalid !== 0 || div_result_valid !== 1'b0)
      $display("FAIL flush_no_valid got %0d pulses want 0", nvalid); else n_pass++;
    n_checks++; if (div_result !== prev)
      $display("FAIL flush_hold got %h want %h", div_result, prev); else n_pass++;
    run_op(2'd0, 32'd9, 32'd3, res, lat, arrc, berr, to);
    exp = exp_q.pop_front(); elat = exp_lat_q.pop_front();
    n_checks++;
    if (to) begin $display("FAIL flush_next_timeout no valid within bound"); return; end
    n_pass++;
    n_checks++; if (res !== exp || lat !== elat)
      $display("FAIL flush_next got %h lat %0d want %h lat %0d", res, lat, exp, elat); else n_pass++;
    @(posedge clk); #1;
    // Request and flush together in IDLE: the request must not be taken.
    div_req = 1'b1; flush = 1'b1; div_op = 2'd0; div_op1 = 32'd8; div_op2 = 32'd2;
    @(posedge clk); #1;
    div_req = 1'b0; flush = 1'b0;
    n_checks++; if (div_busy !== 1'b0 || div_ready !== 1'b1)
      $display("FAIL flush_beats_req got busy=%b ready=%b want 0/1", div_busy, div_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, exp; int lat, arrc, berr, elat; bit to;
    div_req = 1'b1; div_op = 2'd0; div_op1 = 32'd100; div_op2 = 32'd7;
    @(posedge clk); #1;
    div_req = 1'b0;
    n_checks++; if (arr_en !== 1'b1) $display("FAIL mid_array_arr_en got %b want 1", arr_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'd2, 32'd100, 32'd7, res, lat, arrc, berr, to);
    exp = exp_q.pop_front(); elat = exp_lat_q.pop_front();
    n_checks++;
    if (to) begin $display("FAIL reset_recover_timeout no valid within bound"); return; end
    n_pass++;
    n_checks++; if (res !== exp || lat !== elat)
      $display("FAIL reset_recover got %h lat %0d want %h lat %0d", res, lat, exp, elat); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; div_req = 1'b0; div_op = '0; div_op1 = '0; div_op2 = '0; flush = 1'b0;
    #12;
    test_reset();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    test_array();
    test_special();
    test_iter();
    test_flush();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
